// File: rtl/scs8hd_sedfxtp_bank.sv
// scs8hd_sedfxtp_bank: WIDTH-bit holding register with per-bit data enable,
// CHAINS parallel scan chains and a saturating shift-progress counter.
// Build option: define SEDF_BANK_SCO_RETIME_EN to put a lockup flop on each SCO.
module scs8hd_sedfxtp_bank #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CHAINS = 1
) (
    input  logic                                 CLK,
    input  logic                                 RESET,
    input  logic [WIDTH-1:0]                     D,
    input  logic [WIDTH-1:0]                     DE,
    input  logic [CHAINS-1:0]                    SCD,
    input  logic                                 SCE,
    output logic [WIDTH-1:0]                     Q,
    output logic [CHAINS-1:0]                    SCO,
    output logic [$clog2(WIDTH/CHAINS+1)-1:0]    SHIFT_CNT,
    output logic                                 SHIFT_DONE
);

    localparam int unsigned L  = WIDTH / CHAINS;
    localparam int unsigned CW = $clog2(L + 1);

    logic [WIDTH-1:0]  q_r;
    logic [WIDTH-1:0]  q_func;
    logic [WIDTH-1:0]  q_shift;
    logic [WIDTH-1:0]  q_next;
    logic [CHAINS-1:0] chain_lsb;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_next;
    logic              done_r;

    // Functional update: each bit loads D only when its enable is set.
    // Per-bit ternary keeps X on DE[i] visible when D[i] and Q[i] differ.
    always_comb begin
        q_func = q_r;
        for (int i = 0; i < int'(WIDTH); i++) begin
            q_func[i] = DE[i] ? D[i] : q_r[i];
        end
    end

    // Shift path and chain exit bits: SCD enters at the chain MSB, LSB exits.
    for (genvar c = 0; c < int'(CHAINS); c++) begin : g_chain
        if (L == 1) begin : g_single
            assign q_shift[c] = SCD[c];
        end else begin : g_multi
            assign q_shift[c*L +: L] = {SCD[c], q_r[c*L+1 +: L-1]};
        end
        assign chain_lsb[c] = q_r[c*L];
    end

    // Mode select; SCE^SCE is 0 for a known SCE and X otherwise, so an
    // unknown scan enable corrupts every bit in simulation.
    always_comb begin
        q_next = SCE ? q_shift : q_func;
        q_next = q_next ^ {WIDTH{SCE ^ SCE}};
    end

    // Shift counter: counts consecutive shift cycles, saturating at L.
    always_comb begin
        cnt_next = '0;
        if (SCE) begin
            cnt_next = (cnt_r == CW'(L)) ? cnt_r : cnt_r + CW'(1);
        end
    end

    // Register bank, counter and registered done flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_r    <= '0;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else begin
            q_r    <= q_next;
            cnt_r  <= cnt_next;
            done_r <= (cnt_next == CW'(L));
        end
    end

`ifdef SEDF_BANK_SCO_RETIME_EN
    logic [CHAINS-1:0] sco_r;

    // Lockup stage on the scan outputs; runs every cycle in both modes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sco_r <= '0;
        end else begin
            sco_r <= chain_lsb;
        end
    end

    assign SCO = sco_r;
`else
    assign SCO = chain_lsb;
`endif

    assign Q          = q_r;
    assign SHIFT_CNT  = cnt_r;
    assign SHIFT_DONE = done_r;

endmodule

// File: tb/tb_scs8hd_sedfxtp_bank.sv
// Bench for scs8hd_sedfxtp_bank: three configurations (8x1, 8x2, 4x4)
// driven in lockstep, checked against an arithmetic model of the chains.
module tb_scs8hd_sedfxtp_bank;

    logic       CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RESET;
    logic       SCE;
    logic [7:0] D;
    logic [7:0] DE;
    logic       scd_a;
    logic [1:0] scd_b;
    logic [3:0] scd_c;

    logic [7:0] q_a;
    logic       sco_a;
    logic [3:0] cnt_a;
    logic       done_a;
    logic [7:0] q_b;
    logic [1:0] sco_b;
    logic [2:0] cnt_b;
    logic       done_b;
    logic [3:0] q_c;
    logic [3:0] sco_c;
    logic [0:0] cnt_c;
    logic       done_c;

    scs8hd_sedfxtp_bank #(.WIDTH(8), .CHAINS(1)) u_a (
        .CLK(CLK), .RESET(RESET), .D(D), .DE(DE), .SCD(scd_a), .SCE(SCE),
        .Q(q_a), .SCO(sco_a), .SHIFT_CNT(cnt_a), .SHIFT_DONE(done_a)
    );
    scs8hd_sedfxtp_bank #(.WIDTH(8), .CHAINS(2)) u_b (
        .CLK(CLK), .RESET(RESET), .D(D), .DE(DE), .SCD(scd_b), .SCE(SCE),
        .Q(q_b), .SCO(sco_b), .SHIFT_CNT(cnt_b), .SHIFT_DONE(done_b)
    );
    scs8hd_sedfxtp_bank #(.WIDTH(4), .CHAINS(4)) u_c (
        .CLK(CLK), .RESET(RESET), .D(D[3:0]), .DE(DE[3:0]), .SCD(scd_c), .SCE(SCE),
        .Q(q_c), .SCO(sco_c), .SHIFT_CNT(cnt_c), .SHIFT_DONE(done_c)
    );

    int passed = 0;
    int total  = 0;

    // Model state: register contents, shift count, retimed scan-out.
    logic [7:0] mq_a, mq_b, mq_c;
    int         mc_a, mc_b, mc_c;
    logic [7:0] ms_a, ms_b, ms_c;

    // Next register value: each chain is an L-bit number shifted right
    // with the scan-in bit landing at weight 2^(L-1).
    function automatic logic [7:0] model_q(logic [7:0] q, int w, int ch, logic rst,
                                           logic sce, logic [7:0] d, logic [7:0] de,
                                           logic [7:0] scd);
        int len;
        int mask;
        int chain;
        int r;
        len  = w / ch;
        mask = (1 << w) - 1;
        if (rst) return 8'h00;
        if (!sce) return 8'(((int'(q) & ~int'(de)) | (int'(d) & int'(de))) & mask);
        r = 0;
        for (int c = 0; c < ch; c++) begin
            chain = (int'(q) >> (c * len)) & ((1 << len) - 1);
            chain = (chain >> 1) | (int'(scd[c]) << (len - 1));
            r     = r | (chain << (c * len));
        end
        return 8'(r);
    endfunction

    function automatic int model_cnt(int cnt, int len, logic rst, logic sce);
        if (rst || !sce) return 0;
        return (cnt + 1 > len) ? len : cnt + 1;
    endfunction

    function automatic logic [7:0] model_lsbs(logic [7:0] q, int w, int ch);
        logic [7:0] r;
        r = 8'h00;
        for (int c = 0; c < ch; c++) r[c] = q[c * (w / ch)];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one edge: models consume the inputs present at the edge.
    task automatic step();
        @(posedge CLK);
        ms_a = RESET ? 8'h00 : model_lsbs(mq_a, 8, 1);
        ms_b = RESET ? 8'h00 : model_lsbs(mq_b, 8, 2);
        ms_c = RESET ? 8'h00 : model_lsbs(mq_c, 4, 4);
        mq_a = model_q(mq_a, 8, 1, RESET, SCE, D, DE, {7'd0, scd_a});
        mq_b = model_q(mq_b, 8, 2, RESET, SCE, D, DE, {6'd0, scd_b});
        mq_c = model_q(mq_c, 4, 4, RESET, SCE, D, DE, {4'd0, scd_c});
        mc_a = model_cnt(mc_a, 8, RESET, SCE);
        mc_b = model_cnt(mc_b, 4, RESET, SCE);
        mc_c = model_cnt(mc_c, 1, RESET, SCE);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] es_a, es_b, es_c;
`ifdef SEDF_BANK_SCO_RETIME_EN
        es_a = ms_a; es_b = ms_b; es_c = ms_c;
`else
        es_a = model_lsbs(mq_a, 8, 1);
        es_b = model_lsbs(mq_b, 8, 2);
        es_c = model_lsbs(mq_c, 4, 4);
`endif
        check({tag, "_a_q"},    32'(q_a),    32'(mq_a));
        check({tag, "_a_sco"},  32'(sco_a),  32'(es_a[0]));
        check({tag, "_a_cnt"},  32'(cnt_a),  32'(mc_a));
        check({tag, "_a_done"}, 32'(done_a), 32'(mc_a == 8));
        check({tag, "_b_q"},    32'(q_b),    32'(mq_b));
        check({tag, "_b_sco"},  32'(sco_b),  32'(es_b[1:0]));
        check({tag, "_b_cnt"},  32'(cnt_b),  32'(mc_b));
        check({tag, "_b_done"}, 32'(done_b), 32'(mc_b == 4));
        check({tag, "_c_q"},    32'(q_c),    32'(mq_c[3:0]));
        check({tag, "_c_sco"},  32'(sco_c),  32'(es_c[3:0]));
        check({tag, "_c_cnt"},  32'(cnt_c),  32'(mc_c));
        check({tag, "_c_done"}, 32'(done_c), 32'(mc_c == 1));
    endtask

    logic [7:0] pat;

    initial begin
        mq_a = 8'h00; mq_b = 8'h00; mq_c = 8'h00;
        mc_a = 0; mc_b = 0; mc_c = 0;
        ms_a = 8'h00; ms_b = 8'h00; ms_c = 8'h00;
        RESET = 1'b1; SCE = 1'b0; D = 8'hFF; DE = 8'hFF;
        scd_a = 1'b0; scd_b = 2'b00; scd_c = 4'h0;

        // Reset with D/DE all ones still clears everything.
        step();
        check("rst_q", 32'(q_a), 32'h00);
        check("rst_cnt", 32'(cnt_a), 32'h0);
        check("rst_done", 32'(done_a), 32'h0);
        check_all("rst");

        // Per-bit enable load, then hold with DE=0.
        RESET = 1'b0; D = 8'hA5; DE = 8'h0F;
        step();
        check("de_load_q", 32'(q_a), 32'h05);
        check_all("de_load");
        D = 8'hFF; DE = 8'h00;
        step();
        check("de_hold_q", 32'(q_a), 32'h05);
        check_all("de_hold");

        // Single chain: shift in 1,0,1,1,0,0,1,1 from zero, then saturate.
        RESET = 1'b1;
        step();
        RESET = 1'b0; SCE = 1'b1;
        pat = 8'b1100_1101;
        for (int i = 0; i < 8; i++) begin
            scd_a = pat[i];
            scd_b = 2'($urandom_range(0, 3));
            scd_c = 4'($urandom_range(0, 15));
            step();
            check_all("shift8");
        end
        check("shift8_q", 32'(q_a), 32'hCD);
        check("shift8_cnt", 32'(cnt_a), 32'd8);
        check("shift8_done", 32'(done_a), 32'd1);
        step();
        check("shift9_cnt", 32'(cnt_a), 32'd8);
        check_all("shift9");

        // Two chains from 3C, shifting zeros.
        SCE = 1'b0; D = 8'h3C; DE = 8'hFF;
        step();
        check_all("load3c");
        SCE = 1'b1; scd_a = 1'b0; scd_b = 2'b00; scd_c = 4'h0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_all("chain2");
        end
        check("chain2_q", 32'(q_b), 32'h00);
        check("chain2_done", 32'(done_b), 32'd1);

        // Reset in the middle of a shift, then restart.
        SCE = 1'b0; DE = 8'h00;
        step();
        SCE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            scd_a = 1'b1; scd_b = 2'b11; scd_c = 4'hF;
            step();
        end
        RESET = 1'b1;
        step();
        check("midrst_q", 32'(q_a), 32'h00);
        check("midrst_cnt", 32'(cnt_a), 32'd0);
        check_all("midrst");
        RESET = 1'b0;
        step();
        check("restart_cnt", 32'(cnt_a), 32'd1);
        check_all("restart");

        // SCE outranks DE.
        SCE = 1'b0; D = 8'h01; DE = 8'hFF;
        step();
        check_all("load01");
        SCE = 1'b1; D = 8'hFF; DE = 8'hFF; scd_a = 1'b0; scd_b = 2'b00; scd_c = 4'h0;
        step();
        check("prio_q", 32'(q_a), 32'h00);
        check_all("prio");
        step();
        check_all("prio_next");

        // Random traffic, long shift bursts so counters saturate.
        for (int i = 0; i < 400; i++) begin
            RESET = ($urandom_range(0, 29) == 0);
            SCE   = ($urandom_range(0, 9) != 0);
            D     = 8'($urandom);
            DE    = 8'($urandom);
            scd_a = 1'($urandom);
            scd_b = 2'($urandom);
            scd_c = 4'($urandom);
            step();
            check_all("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
